// File: rtl/jtframe_lfbuf_line.sv
// jtframe_lfbuf_line: double-banked game-side line buffer feeding the PSRAM
// line/frame buffer controller. One bank is filled by the object/tile engines
// while the other is handed to the controller for read-out and clearing.
// Also produces the handed-off line number and the frame parity bit.
//
// Optional feature: define JTFRAME_LFBUF_TRANSP_EN to make pixel value 0
// transparent (game writes of 0 are dropped), so several layers can be drawn
// into one bank in priority order.
module jtframe_lfbuf_line #(
    parameter int DW = 16,
    parameter int HW = 9,
    parameter int VW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hs,
    input  logic          vs,
    input  logic [HW-1:0] ln_addr,
    input  logic [DW-1:0] ln_data,
    input  logic          ln_we,
    output logic          ln_rdy,
    output logic          ln_done,
    output logic [VW-1:0] ln_v,
    output logic          frame,
    input  logic [HW-1:0] fb_addr,
    output logic [DW-1:0] fb_din,
    input  logic          fb_clr,
    input  logic          fb_done,
    output logic [7:0]    ln_ovr
);

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        BUSY = 2'd2
    } state_t;

    localparam int DEPTH = 1 << HW;

    state_t        state, state_nx;
    logic [HW-1:0] init_cnt;
    logic          wr_bank;
    logic [VW-1:0] vcnt;
    logic          hs_l, vs_l;
    logic          hs_ev, vs_ev;
    logic          swap, overrun;
    logic          fill_we, clr_we;

    logic [DW-1:0] bank0 [0:DEPTH-1];
    logic [DW-1:0] bank1 [0:DEPTH-1];

    // Sync edges only count once the banks are initialised
    assign hs_ev = hs & ~hs_l & (state != INIT);
    assign vs_ev = vs & ~vs_l & (state != INIT);

`ifdef JTFRAME_LFBUF_TRANSP_EN
    assign fill_we = ln_we && (state != INIT) && (ln_data != '0);
`else
    assign fill_we = ln_we && (state != INIT);
`endif
    assign clr_we  = fb_clr && (state == BUSY);

    // Next-state logic: decides bank swaps and overruns
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        state_nx = state;
        swap     = 1'b0;
        overrun  = 1'b0;
        case (state)
            INIT: if (&init_cnt) state_nx = IDLE;
            IDLE: if (hs_ev) begin
                swap     = 1'b1;
                state_nx = BUSY;
            end
            BUSY: if (hs_ev) begin
                // a bank freed in the same cycle counts as free
                if (fb_done) swap    = 1'b1;
                else         overrun = 1'b1;
            end else if (fb_done) begin
                state_nx = IDLE;
            end
            default: state_nx = INIT;
        endcase
    end

    // Control registers: state, edge detectors, counters and handoff outputs
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
            ln_rdy   <= 1'b0;
            ln_done  <= 1'b0;
            ln_v     <= '0;
            frame    <= 1'b0;
            ln_ovr   <= '0;
            wr_bank  <= 1'b0;
            vcnt     <= '0;
            hs_l     <= 1'b0;
            vs_l     <= 1'b0;
        end else begin
            state   <= state_nx;
            hs_l    <= hs;
            vs_l    <= vs;
            ln_done <= swap;
            if (state == INIT) begin
                init_cnt <= init_cnt + HW'(1);
                if (&init_cnt) ln_rdy <= 1'b1;
            end
            if (swap) begin
                wr_bank <= ~wr_bank;
                ln_v    <= vcnt;
            end
            if (overrun && ln_ovr != 8'hff) ln_ovr <= ln_ovr + 8'd1;
            // vs wins over hs: the handed-off line keeps the pre-clear count
            if (vs_ev) begin
                vcnt  <= '0;
                frame <= ~frame;
            end else if (hs_ev) begin
                vcnt <= vcnt + VW'(1);
            end
        end
    end

    // Bank 0 write port: init clear, game fill or controller clear
    always_ff @(posedge clk) begin
        // NOTE: the memories have no reset; INIT clears them word by word after every rst.
        if (state == INIT)
            bank0[init_cnt] <= '0;
        else if (!wr_bank && fill_we)
            bank0[ln_addr] <= ln_data;
        else if (wr_bank && clr_we)
            bank0[fb_addr] <= '0;
    end

    // Bank 1 write port: init clear, game fill or controller clear
    always_ff @(posedge clk) begin
        if (state == INIT)
            bank1[init_cnt] <= '0;
        else if (wr_bank && fill_we)
            bank1[ln_addr] <= ln_data;
        else if (!wr_bank && clr_we)
            bank1[fb_addr] <= '0;
    end

    // Controller read port: output bank at fb_addr, held outside BUSY
    always_ff @(posedge clk) begin
        if (rst)
            fb_din <= '0;
        else if (state == BUSY)
            fb_din <= wr_bank ? bank0[fb_addr] : bank1[fb_addr];
    end

endmodule

// File: tb/tb_jtframe_lfbuf_line.sv
// Self-checking bench for jtframe_lfbuf_line. A behavioural model of both
// banks, the line counter and the overrun counter produces the expected
// values; read-backs go through a scoreboard queue. Build with or without
// JTFRAME_LFBUF_TRANSP_EN.
module tb_jtframe_lfbuf_line;

`ifdef JTFRAME_LFBUF_TRANSP_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hs = 1'b0, vs = 1'b0;
    logic [8:0]  ln_addr = '0;
    logic [15:0] ln_data = '0;
    logic        ln_we = 1'b0;
    logic        ln_rdy, ln_done, frame;
    logic [7:0]  ln_v;
    logic [8:0]  fb_addr = '0;
    logic [15:0] fb_din;
    logic        fb_clr = 1'b0, fb_done = 1'b0;
    logic [7:0]  ln_ovr;

    jtframe_lfbuf_line #(.DW(16), .HW(9), .VW(8)) dut (
        .clk(clk), .rst(rst), .hs(hs), .vs(vs),
        .ln_addr(ln_addr), .ln_data(ln_data), .ln_we(ln_we),
        .ln_rdy(ln_rdy), .ln_done(ln_done), .ln_v(ln_v), .frame(frame),
        .fb_addr(fb_addr), .fb_din(fb_din), .fb_clr(fb_clr), .fb_done(fb_done),
        .ln_ovr(ln_ovr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    vec_t        vecs [8];
    logic [15:0] sb_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    // model state
    logic [15:0] m_bank [2][512];
    bit          m_wr, m_busy, m_frame;
    logic [7:0]  m_vcnt, m_ln_v, m_ovr;
    logic [15:0] m_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 512; a++) m_bank[b][a] = '0;
        m_wr = 0; m_busy = 0; m_frame = 0;
        m_vcnt = '0; m_ln_v = '0; m_ovr = '0; m_last = '0;
    endtask

    // Reset, check reset values, then time INIT while poking hs and ln_we
    task automatic reset_dut();
        int n;
        rst = 1'b1;
        repeat (3) tick();
        check("rst ln_rdy",  ln_rdy,  0);
        check("rst ln_done", ln_done, 0);
        check("rst ln_v",    ln_v,    0);
        check("rst frame",   frame,   0);
        check("rst fb_din",  fb_din,  0);
        check("rst ln_ovr",  ln_ovr,  0);
        model_reset();
        // NOTE: inputs are driven with blocking assignments 1 time unit after the edge, away from sampling.
        rst = 1'b0;
        ln_addr = 9'd3; ln_data = 16'hbeef; ln_we = 1'b1;
        n = 0;
        while (!ln_rdy && n < 2000) begin
            hs = n[3];
            tick();
            n++;
        end
        ln_we = 1'b0;
        hs = 1'b0;
        check("init cycles", n, 512);
        tick();
    endtask

    // One sync/done event followed by a release cycle
    task automatic ev(input bit h, input bit v, input bit d, input string name);
        bit sw;
        sw = h && (!m_busy || d);
        if (h) begin
            if (sw) begin
                m_ln_v = m_vcnt;
                m_wr   = ~m_wr;
                m_busy = 1;
            end else if (m_ovr != 8'hff) begin
                m_ovr++;
            end
        end else if (d) begin
            m_busy = 0;
        end
        if (v) begin
            m_vcnt  = '0;
            m_frame = ~m_frame;
        end else if (h) begin
            m_vcnt++;
        end
        hs = h; vs = v; fb_done = d;
        tick();
        check({name, " ln_done"}, ln_done, sw);
        check({name, " ln_v"},    ln_v,    m_ln_v);
        check({name, " frame"},   frame,   m_frame);
        check({name, " ln_ovr"},  ln_ovr,  m_ovr);
        hs = 0; vs = 0; fb_done = 0;
        tick();
        check({name, " ln_done off"}, ln_done, 0);
    endtask

    task automatic game_write(input int a, input logic [15:0] d);
        ln_addr = 9'(a); ln_data = d; ln_we = 1'b1;
        if (!(TRANSP && d == 16'h0)) m_bank[m_wr][a] = d;
        tick();
        ln_we = 1'b0;
    endtask

    // Controller read with an explicit expected value
    task automatic rd_x(input int a, input bit clr, input logic [15:0] exp, input string name);
        logic [15:0] e;
        fb_addr = 9'(a); fb_clr = clr;
        sb_q.push_back(exp);
        m_last = exp;
        if (clr) m_bank[int'(~m_wr)][a] = '0;
        tick();
        e = sb_q.pop_front();
        check(name, fb_din, e);
        fb_clr = 1'b0;
    endtask

    task automatic rd(input int a, input bit clr, input string name);
        rd_x(a, clr, m_bank[int'(~m_wr)][a], name);
    endtask

    task automatic sweep(input bit clr, input string name);
        for (int a = 0; a < 512; a++) rd(a, clr, name);
    endtask

    initial begin
        vecs[0] = '{9'd0,   16'h0001, 16'h0001};
        vecs[1] = '{9'd1,   16'hffff, 16'hffff};
        vecs[2] = '{9'd17,  16'h5a5a, 16'h5a5a};
        vecs[3] = '{9'd100, 16'h0000, 16'h0000};
        vecs[4] = '{9'd255, 16'h8000, 16'h8000};
        vecs[5] = '{9'd256, 16'h7fff, 16'h7fff};
        vecs[6] = '{9'd510, 16'hc3c3, 16'hc3c3};
        vecs[7] = '{9'd511, 16'h2468, 16'h2468};

        reset_dut();

        // first handoff: initial bank must read all zero
        ev(1, 0, 0, "hs0");
        sweep(1, "bank0 init");
        ev(0, 0, 1, "done0");

        // single write, handoff and read-back
        game_write(5, 16'h1234);
        ev(1, 0, 0, "hs1");
        rd(5, 0, "x5 read");
        sweep(1, "bank1 clr sweep");
        ev(0, 0, 1, "done1");
        ev(1, 0, 0, "hs2");
        ev(0, 0, 1, "done2");
        ev(1, 0, 0, "hs3");
        sweep(0, "cleared bank");

        // table-driven fill while the other bank is busy
        for (int i = 0; i < 8; i++) game_write(vecs[i].addr, vecs[i].data);
        ev(0, 0, 1, "done3");
        ev(1, 0, 0, "hs4");
        for (int i = 0; i < 8; i++) rd_x(vecs[i].addr, 0, vecs[i].exp, "table read");

        // overruns, saturating at 255
        ev(1, 0, 0, "ovr1");
        check("ovr count 1", ln_ovr, 1);
        for (int i = 0; i < 300; i++) ev(1, 0, 0, "ovr");
        check("ovr saturate", ln_ovr, 255);

        // fb_done with hs: swap, not an overrun
        ev(1, 0, 1, "done+hs");
        ev(0, 0, 1, "done4");
        ev(1, 1, 0, "vs+hs");
        ev(0, 0, 1, "done5");
        ev(1, 0, 0, "hs after vs");
        check("ln_v after vs", ln_v, 0);
        ev(0, 0, 1, "done6");
        ev(1, 0, 0, "hs after vs 2");
        check("ln_v second", ln_v, 1);
        ev(0, 1, 0, "vs only");

        // transparency of zero writes
        game_write(7, 16'habcd);
        game_write(7, 16'h0000);
        ev(0, 0, 1, "done7");
        ev(1, 0, 0, "hs transp");
        rd_x(7, 0, TRANSP ? 16'habcd : 16'h0000, "x7 transp");

        // fb_din holds and fb_clr is ignored outside BUSY
        ev(0, 0, 1, "done8");
        fb_addr = 9'd8; fb_clr = 1'b1;
        tick();
        fb_clr = 1'b0;
        check("fb_din hold", fb_din, m_last);
        ev(1, 0, 0, "hs idle clr");
        rd(7, 0, "x7 after idle clr");

        // reset while busy: everything cleared again
        reset_dut();
        ev(1, 0, 0, "post rst hs");
        sweep(0, "post rst bank0");
        ev(0, 0, 1, "post rst done");
        ev(1, 0, 0, "post rst hs2");
        sweep(0, "post rst bank1");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
